// File: rtl/async_fifo_pkg.sv
// Shared types for the FWFT read adapter behind async_fifo.
// Optional feature macro used by the adapter: ASYNC_FIFO_FWFT_COUNT_EN.
package async_fifo_pkg;

    localparam int FWFT_DEPTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fwft_occ_e;

endpackage

// File: rtl/fwft_skid_buffer.sv
// Two-entry head/tail output buffer with its occupancy FSM.
// The head register always drives the output word and is held while the consumer stalls.
module fwft_skid_buffer
    import async_fifo_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [BITS-1:0] push_data_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [BITS-1:0] head_o,
    output logic [1:0]      occ_o
);

    fwft_occ_e       occ_q;
    logic [BITS-1:0] head_q;
    logic [BITS-1:0] tail_q;
    logic            pop;

    assign valid_o = (occ_q != EMPTY);
    assign pop     = valid_o && ready_i;
    assign head_o  = head_q;
    assign occ_o   = occ_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (push_i) begin
                        head_q <= push_data_i;
                        occ_q  <= ONE;
                    end
                end
                ONE: begin
                    if (push_i && pop) begin
                        head_q <= push_data_i;
                    end else if (push_i) begin
                        tail_q <= push_data_i;
                        occ_q  <= TWO;
                    end else if (pop) begin
                        occ_q  <= EMPTY;
                    end
                end
                TWO: begin
                    // Tail advances to head; a concurrent arrival refills the tail.
                    if (pop) begin
                        head_q <= tail_q;
                        if (push_i) begin
                            tail_q <= push_data_i;
                        end else begin
                            occ_q  <= ONE;
                        end
                    end
                end
                default: occ_q <= EMPTY;
            endcase
        end
    end

    // The issue logic never requests a word that would land in a full buffer.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((occ_q == TWO) && push_i && !pop));

endmodule

// File: rtl/async_fifo_fwft_adapter.sv
// Converts async_fifo's request/empty read port into a first-word-fall-through valid/ready stream.
// Define ASYNC_FIFO_FWFT_COUNT_EN to add the p_out_count accepted-word counter port.
module async_fifo_fwft_adapter
    import async_fifo_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic            read_clk,
    input  logic            read_rst_n,
    output logic            p_fifo_read_en,
    input  logic [BITS-1:0] p_fifo_read_data,
    input  logic            p_fifo_read_empty,
    output logic            p_out_valid,
    input  logic            p_out_ready,
    output logic [BITS-1:0] p_out_data
`ifdef ASYNC_FIFO_FWFT_COUNT_EN
    ,
    output logic [31:0]     p_out_count
`endif
);

    logic       inflight_q;
    logic       pop;
    logic [1:0] occ;
    logic [2:0] demand;

    assign pop    = p_out_valid && p_out_ready;
    // Words held plus the word on its way, minus the one leaving this cycle.
    assign demand = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

    assign p_fifo_read_en = read_rst_n && !p_fifo_read_empty
                            && (demand < 3'(FWFT_DEPTH));

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= p_fifo_read_en;
        end
    end

    fwft_skid_buffer #(
        .BITS (BITS)
    ) u_skid (
        .clk_i       (read_clk),
        .rst_ni      (read_rst_n),
        .push_i      (inflight_q),
        .push_data_i (p_fifo_read_data),
        .ready_i     (p_out_ready),
        .valid_o     (p_out_valid),
        .head_o      (p_out_data),
        .occ_o       (occ)
    );

`ifdef ASYNC_FIFO_FWFT_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign p_out_count = count_q;
`endif

endmodule

// File: tb/tb_async_fifo_fwft_adapter.sv
// Scoreboard bench for async_fifo_fwft_adapter driven by a behavioural async_fifo read-port model.
module tb_async_fifo_fwft_adapter;

    localparam int BITS = 32;

    logic            read_clk = 1'b0;
    logic            read_rst_n = 1'b0;
    logic            p_fifo_read_en;
    logic [BITS-1:0] p_fifo_read_data = '0;
    logic            p_fifo_read_empty = 1'b1;
    logic            p_out_valid;
    logic            p_out_ready = 1'b0;
    logic [BITS-1:0] p_out_data;
`ifdef ASYNC_FIFO_FWFT_COUNT_EN
    logic [31:0]     p_out_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [BITS-1:0] wr_q[$];
    logic [BITS-1:0] fifo_q[$];
    logic [BITS-1:0] exp_q[$];

    async_fifo_fwft_adapter #(
        .BITS (BITS)
    ) dut (
        .read_clk          (read_clk),
        .read_rst_n        (read_rst_n),
        .p_fifo_read_en    (p_fifo_read_en),
        .p_fifo_read_data  (p_fifo_read_data),
        .p_fifo_read_empty (p_fifo_read_empty),
        .p_out_valid       (p_out_valid),
        .p_out_ready       (p_out_ready),
        .p_out_data        (p_out_data)
`ifdef ASYNC_FIFO_FWFT_COUNT_EN
        ,
        .p_out_count       (p_out_count)
`endif
    );

    always #5 read_clk = ~read_clk;

    // Read side of async_fifo: data one cycle after read_en, shares the reset.
    always @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            fifo_q.delete();
            p_fifo_read_data  <= '0;
            p_fifo_read_empty <= 1'b1;
        end else begin
            if (p_fifo_read_en && fifo_q.size() > 0) begin
                p_fifo_read_data <= fifo_q.pop_front();
            end
            while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
            p_fifo_read_empty <= (fifo_q.size() == 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted word must be the next one written.
    always @(negedge read_clk) begin
        if (read_rst_n && p_out_valid && p_out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", p_out_data);
            end else begin
                check("out_data", {32'd0, p_out_data}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge read_clk);
            #1;
        end
    endtask

    task automatic fifo_write(input logic [BITS-1:0] d);
        wr_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic do_reset();
        read_rst_n = 1'b0;
        exp_q.delete();
        wr_q.delete();
        tick(3);
        read_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || p_out_valid) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_count(input string name, input logic [31:0] exp);
`ifdef ASYNC_FIFO_FWFT_COUNT_EN
        check(name, {32'd0, p_out_count}, {32'd0, exp});
`else
        if (exp == 32'hFFFF_FFFF) $display("count %s unused", name);
`endif
    endtask

    initial begin
        int vcnt;
        int rcnt;
        int hchg;
        int n;

        // Reset with the FIFO empty
        p_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("rst_valid", 64'(p_out_valid), 64'd0);
            check("rst_rd_en", 64'(p_fifo_read_en), 64'd0);
            check("rst_data", {32'd0, p_out_data}, 64'd0);
        end
        check_count("rst_count", 32'd0);
        read_rst_n = 1'b1;
        tick(1);

        // Single word: valid two cycles after empty falls, drops after acceptance
        do_reset();
        p_out_ready = 1'b1;
        fifo_write(32'hDEADBEEF);
        tick(1);
        check("sw_empty_fell", 64'(p_fifo_read_empty), 64'd0);
        check("sw_rd_en_n0", 64'(p_fifo_read_en), 64'd1);
        check("sw_valid_n0", 64'(p_out_valid), 64'd0);
        tick(1);
        check("sw_valid_n1", 64'(p_out_valid), 64'd0);
        check("sw_rd_en_n1", 64'(p_fifo_read_en), 64'd0);
        tick(1);
        check("sw_valid_n2", 64'(p_out_valid), 64'd1);
        check("sw_data_n2", {32'd0, p_out_data}, 64'hDEADBEEF);
        tick(1);
        check("sw_valid_n3", 64'(p_out_valid), 64'd0);
        check("sw_drained", 64'(exp_q.size()), 64'd0);

        // Streaming 0..15 with ready high: one word per cycle after fill
        do_reset();
        p_out_ready = 1'b1;
        for (int i = 0; i < 16; i++) fifo_write(32'(i));
        tick(3);
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (p_out_valid) vcnt++;
            tick(1);
        end
        check("stream_valid_cycles", 64'(vcnt), 64'd16);
        check("stream_valid_after", 64'(p_out_valid), 64'd0);
        check("stream_drained", 64'(exp_q.size()), 64'd0);
        check_count("stream_count", 32'd16);

        // Backpressure: exactly two reads while stalled, head held at word 0
        do_reset();
        p_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) fifo_write(32'(i));
        tick(1);
        rcnt = 0;
        hchg = 0;
        for (int i = 0; i < 20; i++) begin
            if (p_fifo_read_en) rcnt++;
            if (p_out_valid && p_out_data != '0) hchg++;
            tick(1);
        end
        check("bp_reads", 64'(rcnt), 64'd2);
        check("bp_rd_en_stalled", 64'(p_fifo_read_en), 64'd0);
        check("bp_valid", 64'(p_out_valid), 64'd1);
        check("bp_head", {32'd0, p_out_data}, 64'd0);
        check("bp_head_changes", 64'(hchg), 64'd0);
        p_out_ready = 1'b1;
        #1;
        check("bp_resume_rd_en", 64'(p_fifo_read_en), 64'd1);
        wait_drain("bp_drained", 100);
        check_count("bp_count", 32'd16);

        // Random ready over 1000 random words
        do_reset();
        for (int i = 0; i < 1000; i++) fifo_write($urandom);
        n = 0;
        while (exp_q.size() != 0 && n < 6000) begin
            p_out_ready = 1'($urandom_range(0, 1));
            tick(1);
            n++;
        end
        p_out_ready = 1'b1;
        wait_drain("rand_drained", 20);
        check_count("rand_count", 32'd1000);

        // Reset while a word is held and another is in flight
        do_reset();
        p_out_ready = 1'b0;
        fifo_write(32'hA0A0_0001);
        fifo_write(32'hA0A0_0002);
        fifo_write(32'hA0A0_0003);
        tick(3);
        check("mid_valid_before", 64'(p_out_valid), 64'd1);
        read_rst_n = 1'b0;
        exp_q.delete();
        wr_q.delete();
        #1;
        check("mid_valid_async", 64'(p_out_valid), 64'd0);
        check("mid_rd_en_async", 64'(p_fifo_read_en), 64'd0);
        check("mid_data_async", {32'd0, p_out_data}, 64'd0);
        tick(2);
        read_rst_n = 1'b1;
        tick(1);
        check_count("mid_count_cleared", 32'd0);
        p_out_ready = 1'b1;
        fifo_write(32'h12345678);
        tick(3);
        check("mid_new_valid", 64'(p_out_valid), 64'd1);
        check("mid_new_data", {32'd0, p_out_data}, 64'h12345678);
        wait_drain("mid_drained", 20);
        check_count("mid_count", 32'd1);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
